// File: rtl/conv3x3_stream_pkg.sv
// rtl/conv3x3_stream_pkg.sv - shared types and arithmetic helpers for the 3x3 convolution engine
package conv_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} conv_state_t;

  typedef enum logic [1:0] {CLAMP_PASS, CLAMP_LOW, CLAMP_HIGH} clamp_t;

  // Product is pixel+weight+1 bits signed; nine of them need 4 more bits of headroom.
  function automatic int acc_width(input int pix_bits, input int wt_bits);
    return pix_bits + wt_bits + 1 + 4;
  endfunction

  function automatic clamp_t clamp_class(input logic signed [47:0] v, input int pix_bits);
    logic signed [47:0] max_v;
    max_v = (48'sd1 <<< pix_bits) - 48'sd1;
    if (v < 48'sd0) return CLAMP_LOW;
    if (v > max_v) return CLAMP_HIGH;
    return CLAMP_PASS;
  endfunction

endpackage

// File: rtl/conv3x3_stream_line_buffer.sv
// rtl/conv3x3_stream_line_buffer.sv - one-row circular pixel store, read-before-write at one index
module line_buffer #(
  parameter int DEPTH = 28,
  parameter int WIDTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic [AW-1:0]    idx_i,
  input  logic             we_i,
  input  logic [WIDTH-1:0] wr_data_i,
  output logic [WIDTH-1:0] rd_data_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  assign rd_data_o = mem_q[idx_i];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[idx_i] <= wr_data_i;
  end

endmodule

// File: rtl/conv3x3_stream.sv
// rtl/conv3x3_stream.sv - streaming 3x3 valid-mode convolution with shift and ReLU clamp
module conv3x3_stream
  import conv_pkg::*;
#(
  parameter int IMG_WIDTH   = 28,
  parameter int IMG_HEIGHT  = 28,
  parameter int PIXEL_SIZE  = 8,
  parameter int WEIGHT_SIZE = 8,
  parameter int SHIFT       = 0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [9*WEIGHT_SIZE-1:0] kernel,
  input  logic [PIXEL_SIZE-1:0]    in_pixel,
  input  logic                     in_valid,
  output logic [PIXEL_SIZE-1:0]    pixel,
  output logic                     pixel_valid,
  output logic                     conv_done
);

  localparam int PROD_W = PIXEL_SIZE + WEIGHT_SIZE + 1;
  localparam int ACC_W  = acc_width(PIXEL_SIZE, WEIGHT_SIZE);
  localparam int COL_W  = $clog2(IMG_WIDTH);
  localparam int ROW_W  = $clog2(IMG_HEIGHT);

  conv_state_t state_q, state_d;
  logic drain_q, drain_d;
  logic [COL_W-1:0] col_q, col_d;
  logic [ROW_W-1:0] row_q, row_d;

  logic accept, last_in, win_full;
  logic [PIXEL_SIZE-1:0] lb0_rd, lb1_rd;
  logic [PIXEL_SIZE-1:0] nc [3];
  logic [PIXEL_SIZE-1:0] win_q [3][2];
  logic [PIXEL_SIZE-1:0] px [9];
  logic signed [PROD_W-1:0] prod [9];
  logic signed [ACC_W-1:0] sum_d, acc_q, acc_sh;
  logic signed [47:0] acc_ext;
  logic acc_v_q, pv_q;
  logic [PIXEL_SIZE-1:0] pixel_q, pixel_d;

  // A start pulse wins over any pixel presented on the same cycle.
  assign accept   = (state_q == RUN) && in_valid && !start;
  assign last_in  = (col_q == COL_W'(IMG_WIDTH - 1)) && (row_q == ROW_W'(IMG_HEIGHT - 1));
  assign win_full = (col_q >= COL_W'(2)) && (row_q >= ROW_W'(2));

  line_buffer #(.DEPTH(IMG_WIDTH), .WIDTH(PIXEL_SIZE)) u_lb0 (
    .clk(clk), .idx_i(col_q), .we_i(accept), .wr_data_i(lb1_rd), .rd_data_o(lb0_rd)
  );

  line_buffer #(.DEPTH(IMG_WIDTH), .WIDTH(PIXEL_SIZE)) u_lb1 (
    .clk(clk), .idx_i(col_q), .we_i(accept), .wr_data_i(in_pixel), .rd_data_o(lb1_rd)
  );

  assign nc[0] = lb0_rd;
  assign nc[1] = lb1_rd;
  assign nc[2] = in_pixel;

  always_comb begin
    state_d = state_q;
    drain_d = drain_q;
    col_d   = col_q;
    row_d   = row_q;
    if (start) begin
      state_d = RUN;
      drain_d = 1'b0;
      col_d   = '0;
      row_d   = '0;
    end else begin
      case (state_q)
        RUN: begin
          if (accept) begin
            if (col_q == COL_W'(IMG_WIDTH - 1)) begin
              col_d = '0;
              row_d = row_q + 1'b1;
            end else begin
              col_d = col_q + 1'b1;
            end
            if (last_in) begin
              state_d = DRAIN;
              drain_d = 1'b0;
            end
          end
        end
        // Two cycles: one for the sum stage, one for the output register.
        DRAIN: begin
          drain_d = 1'b1;
          if (drain_q) state_d = DONE;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      drain_q <= 1'b0;
      col_q   <= '0;
      row_q   <= '0;
    end else begin
      state_q <= state_d;
      drain_q <= drain_d;
      col_q   <= col_d;
      row_q   <= row_d;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      for (int r = 0; r < 3; r++) begin
        win_q[r][0] <= win_q[r][1];
        win_q[r][1] <= nc[r];
      end
    end
  end

  // Sum over the window as it will look after this accept: two stored columns plus the incoming one.
  always_comb begin
    logic [WEIGHT_SIZE-1:0] w;
    w     = '0;
    sum_d = '0;
    for (int r = 0; r < 3; r++) begin
      px[3*r]     = win_q[r][0];
      px[3*r + 1] = win_q[r][1];
      px[3*r + 2] = nc[r];
    end
    for (int k = 0; k < 9; k++) begin
      w       = kernel[k*WEIGHT_SIZE +: WEIGHT_SIZE];
      prod[k] = $signed({{(WEIGHT_SIZE + 1){1'b0}}, px[k]}) *
                $signed({{(PIXEL_SIZE + 1){w[WEIGHT_SIZE-1]}}, w});
      sum_d   = sum_d + $signed({{4{prod[k][PROD_W-1]}}, prod[k]});
    end
  end

  assign acc_sh  = acc_q >>> SHIFT;
  assign acc_ext = {{(48 - ACC_W){acc_sh[ACC_W-1]}}, acc_sh};

  always_comb begin
    pixel_d = acc_sh[PIXEL_SIZE-1:0];
    case (clamp_class(acc_ext, PIXEL_SIZE))
      CLAMP_LOW:  pixel_d = '0;
      CLAMP_HIGH: pixel_d = '1;
      default:    ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q   <= '0;
      acc_v_q <= 1'b0;
      pv_q    <= 1'b0;
      pixel_q <= '0;
    end else if (start) begin
      acc_v_q <= 1'b0;
      pv_q    <= 1'b0;
    end else begin
      acc_v_q <= accept && win_full;
      if (accept) acc_q <= sum_d;
      pv_q <= acc_v_q;
      if (acc_v_q) pixel_q <= pixel_d;
    end
  end

  assign pixel       = pixel_q;
  assign pixel_valid = pv_q;
  assign conv_done   = (state_q == DONE);

endmodule
